operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/dibu_pkg.sv | 25 ++
 rtl/operand_scoreboard.sv | 55 +++++
 rtl/operand_fetch.sv | 183 ++++++++++++++++++
 tb/tb_operand_fetch.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dibu_pkg.sv
// Shared definitions for the operand fetch stage.
// Holds the datapath widths, the fetch FSM state encoding and a one-hot
// index decoder used by the register scoreboard.
package dibu_pkg;

    localparam int DATA_W    = 8;
    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 8;
    localparam int OP_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_LATCH = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_t;

    // One-hot mask selecting register idx.
    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] one;
        one = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Register scoreboard: one pending bit per architectural register.
// Ports:
//   clk, rst           clock, synchronous active-high reset (clears all bits)
//   set_en, set_idx    mark register set_idx as awaiting writeback
//   clr_en, clr_idx    writeback arrived for register clr_idx
//   query_a, query_b   source indices of the instruction being offered
//   hazard             1 when either queried register is pending
// A set and a clear to the same index in one cycle leaves the bit set.
// The query reads the registered vector, so a clear is seen one cycle later.
module operand_scoreboard
    import dibu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] query_a,
    input  logic [REG_IDX_W-1:0] query_b,
    output logic                 hazard
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Decode set/clear requests into masks.
    always_comb begin
        set_mask = {NUM_REGS{1'b0}};
        clr_mask = {NUM_REGS{1'b0}};
        if (set_en) begin
            set_mask = idx_onehot(set_idx);
        end else begin
            set_mask = {NUM_REGS{1'b0}};
        end
        if (clr_en) begin
            clr_mask = idx_onehot(clr_idx);
        end else begin
            clr_mask = {NUM_REGS{1'b0}};
        end
    end

    // Pending vector: clear first, then OR in the set so the set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= {NUM_REGS{1'b0}};
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    assign hazard = pending[query_a] | pending[query_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts one decoded instruction at a time, reads its
// two source operands from an external registered register bank and offers
// them downstream with a valid/ready handshake. Writebacks are forwarded to
// the bank every cycle and always take priority over a read; a read that
// collides with a writeback is simply retried.
// Build option: DIBU_SCOREBOARD_EN adds a pending-register scoreboard that
// stalls instructions whose sources await writeback; without it the stage
// never stalls in IDLE.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready, in_op, in_ri_a, in_ri_b, in_ri_d, in_wen
//                                  decoded instruction input
//   rb_ri_a, rb_ri_b, rb_ri_d, rb_rw, rb_d, rb_a, rb_b
//                                  register bank interface
//   out_valid/out_ready, out_op, out_a, out_b, out_ri_d, out_wen
//                                  fetched instruction output
//   wb_valid, wb_ri_d, wb_d        writeback request (no backpressure)
module operand_fetch
    import dibu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      in_op,
    input  logic [REG_IDX_W-1:0] in_ri_a,
    input  logic [REG_IDX_W-1:0] in_ri_b,
    input  logic [REG_IDX_W-1:0] in_ri_d,
    input  logic                 in_wen,
    output logic [REG_IDX_W-1:0] rb_ri_a,
    output logic [REG_IDX_W-1:0] rb_ri_b,
    output logic [REG_IDX_W-1:0] rb_ri_d,
    output logic                 rb_rw,
    output logic [DATA_W-1:0]    rb_d,
    input  logic [DATA_W-1:0]    rb_a,
    input  logic [DATA_W-1:0]    rb_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_W-1:0]      out_op,
    output logic [DATA_W-1:0]    out_a,
    output logic [DATA_W-1:0]    out_b,
    output logic [REG_IDX_W-1:0] out_ri_d,
    output logic                 out_wen,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_ri_d,
    input  logic [DATA_W-1:0]    wb_d
);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic                  hazard;
    logic                  accept;
    logic [OP_W-1:0]       lat_op;
    logic [REG_IDX_W-1:0]  lat_ri_a;
    logic [REG_IDX_W-1:0]  lat_ri_b;
    logic [REG_IDX_W-1:0]  lat_ri_d;
    logic                  lat_wen;
    logic [DATA_W-1:0]     opnd_a;
    logic [DATA_W-1:0]     opnd_b;

`ifdef DIBU_SCOREBOARD_EN
    logic out_fire;

    assign out_fire = out_valid & out_ready & lat_wen;

    operand_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (out_fire),
        .set_idx (lat_ri_d),
        .clr_en  (wb_valid & ~rst),
        .clr_idx (wb_ri_d),
        .query_a (in_ri_a),
        .query_b (in_ri_b),
        .hazard  (hazard)
    );
`else
    assign hazard = 1'b0;
`endif

    assign accept = in_valid & in_ready;

    // Writeback owns the bank write port whenever it is present; reset masks it.
    assign rb_rw   = wb_valid & ~rst;
    assign rb_ri_d = wb_ri_d;
    assign rb_d    = wb_d;
    // Read indices stay on the latched sources, so any rw=0 cycle reads them.
    assign rb_ri_a = lat_ri_a;
    assign rb_ri_b = lat_ri_b;

    assign out_op   = lat_op;
    assign out_a    = opnd_a;
    assign out_b    = opnd_b;
    assign out_ri_d = lat_ri_d;
    assign out_wen  = lat_wen;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; a writeback in READ forces a retry of the read.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_READ;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_READ: begin
                if (wb_valid) begin
                    state_next = ST_READ;
                end else begin
                    state_next = ST_LATCH;
                end
            end
            ST_LATCH: begin
                state_next = ST_VALID;
            end
            ST_VALID: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_VALID;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs; both handshake outputs are forced low while in reset.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = ~rst & ~hazard;
            end
            ST_VALID: begin
                out_valid = ~rst;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Instruction fields latched on accept; operands captured in LATCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_op   <= {OP_W{1'b0}};
            lat_ri_a <= {REG_IDX_W{1'b0}};
            lat_ri_b <= {REG_IDX_W{1'b0}};
            lat_ri_d <= {REG_IDX_W{1'b0}};
            lat_wen  <= 1'b0;
            opnd_a   <= {DATA_W{1'b0}};
            opnd_b   <= {DATA_W{1'b0}};
        end else begin
            if (accept) begin
                lat_op   <= in_op;
                lat_ri_a <= in_ri_a;
                lat_ri_b <= in_ri_b;
                lat_ri_d <= in_ri_d;
                lat_wen  <= in_wen;
            end
            if (state == ST_LATCH) begin
                opnd_a <= rb_a;
                opnd_b <= rb_b;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a registered register-bank environment, a
// transaction-level reference model stepped once per cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_operand_fetch;

`ifdef DIBU_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_op;
    logic [2:0] in_ri_a, in_ri_b, in_ri_d;
    logic       in_wen;
    logic [2:0] rb_ri_a, rb_ri_b, rb_ri_d;
    logic       rb_rw;
    logic [7:0] rb_d, rb_a, rb_b;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_op;
    logic [7:0] out_a, out_b;
    logic [2:0] out_ri_d;
    logic       out_wen;
    logic       wb_valid;
    logic [2:0] wb_ri_d;
    logic [7:0] wb_d;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_ri_a(in_ri_a), .in_ri_b(in_ri_b), .in_ri_d(in_ri_d), .in_wen(in_wen),
        .rb_ri_a(rb_ri_a), .rb_ri_b(rb_ri_b), .rb_ri_d(rb_ri_d), .rb_rw(rb_rw),
        .rb_d(rb_d), .rb_a(rb_a), .rb_b(rb_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_a(out_a), .out_b(out_b), .out_ri_d(out_ri_d), .out_wen(out_wen),
        .wb_valid(wb_valid), .wb_ri_d(wb_ri_d), .wb_d(wb_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank environment: write when rw=1, otherwise registered read.
    logic [7:0] bank [8];
    always_ff @(posedge clk) begin
        if (rb_rw) begin
            bank[rb_ri_d] <= rb_d;
        end else begin
            rb_a <= bank[rb_ri_a];
            rb_b <= bank[rb_ri_b];
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model state (transaction level).
    logic [7:0] m_regs [8];
    logic [7:0] m_pend;
    bit         m_busy, m_read_ok, m_valid;
    logic [4:0] m_op;
    logic [2:0] m_a_idx, m_b_idx, m_d_idx;
    logic       m_wen;
    logic [7:0] m_a, m_b;

    // Samples of DUT outputs from the latest cycle.
    logic       s_in_ready, s_out_valid, s_rb_rw;
    logic [7:0] s_out_a, s_out_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 8'h00; m_busy = 1'b0; m_read_ok = 1'b0; m_valid = 1'b0;
        m_op = 5'h00; m_a_idx = 3'd0; m_b_idx = 3'd0; m_d_idx = 3'd0; m_wen = 1'b0;
    endtask

    // One clock cycle: inputs already set; compare, advance model, clock.
    task automatic cycle();
        bit e_in_ready, e_out_valid, haz, hs;
        #1;
        haz = SB && (m_pend[in_ri_a] || m_pend[in_ri_b]);
        e_in_ready  = !rst && !m_busy && !haz;
        e_out_valid = !rst && m_valid;
        s_in_ready = in_ready; s_out_valid = out_valid; s_rb_rw = rb_rw;
        s_out_a = out_a; s_out_b = out_b;
        chk("in_ready", in_ready, e_in_ready);
        chk("out_valid", out_valid, e_out_valid);
        chk("rb_rw", rb_rw, wb_valid && !rst);
        chk("rb_ri_d", rb_ri_d, wb_ri_d);
        chk("rb_d", rb_d, wb_d);
        chk("rb_ri_a", rb_ri_a, m_a_idx);
        chk("rb_ri_b", rb_ri_b, m_b_idx);
        if (e_out_valid) begin
            chk("out_op", out_op, m_op);
            chk("out_a", out_a, m_a);
            chk("out_b", out_b, m_b);
            chk("out_ri_d", out_ri_d, m_d_idx);
            chk("out_wen", out_wen, m_wen);
        end
        if (rst) begin
            model_reset();
        end else begin
            hs = m_valid && out_ready;
            if (hs) begin
                m_busy = 1'b0; m_valid = 1'b0; m_read_ok = 1'b0;
            end else if (m_busy && m_read_ok) begin
                m_valid = 1'b1;
            end else if (m_busy && !wb_valid) begin
                m_read_ok = 1'b1;
                m_a = m_regs[m_a_idx];
                m_b = m_regs[m_b_idx];
            end else if (!m_busy && in_valid && e_in_ready) begin
                m_busy = 1'b1;
                m_op = in_op; m_a_idx = in_ri_a; m_b_idx = in_ri_b;
                m_d_idx = in_ri_d; m_wen = in_wen;
            end
            if (wb_valid) begin
                m_regs[wb_ri_d] = wb_d;
                m_pend[wb_ri_d] = 1'b0;
            end
            if (hs && m_wen) m_pend[m_d_idx] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input logic wen);
        in_valid = 1'b1; in_op = op; in_ri_a = a; in_ri_b = b; in_ri_d = d; in_wen = wen;
        cycle();
        chk("accept", s_in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            n++;
            if (s_out_valid) break;
        end
        chk("valid_timeout", s_out_valid, 1'b1);
    endtask

    task automatic wb(input logic [2:0] idx, input logic [7:0] d);
        wb_valid = 1'b1; wb_ri_d = idx; wb_d = d;
        cycle();
        wb_valid = 1'b0;
    endtask

    initial begin
        int n, n2;
        rst = 1'b1; in_valid = 1'b0; in_op = 5'h00; in_ri_a = 3'd0; in_ri_b = 3'd0;
        in_ri_d = 3'd0; in_wen = 1'b0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_ri_d = 3'd0; wb_d = 8'h00;
        model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        @(negedge clk);
        // Reset with a writeback offered: must be ignored.
        wb_valid = 1'b1; wb_ri_d = 3'd1; wb_d = 8'h5A;
        cycle();
        chk("rst_rb_rw", s_rb_rw, 1'b0);
        wb_valid = 1'b0;
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_out_a", out_a, 8'h00);
        chk("rst_out_op", out_op, 5'h00);
        chk("rst_out_wen", out_wen, 1'b0);
        chk("rst_idle_ready", in_ready, 1'b1);
        @(negedge clk);

        // Initialise every bank register through the writeback port.
        for (int i = 0; i < 8; i++) wb(3'(i), 8'($urandom));

        // Basic fetch, latency 3.
        out_ready = 1'b1;
        wb(3'd2, 8'h15);
        wb(3'd5, 8'hA0);
        issue(5'h0A, 3'd2, 3'd5, 3'd1, 1'b0);
        wait_valid(n);
        chk("t030_latency", n, 3);
        chk("t030_a", s_out_a, 8'h15);
        chk("t030_b", s_out_b, 8'hA0);

        // Writeback during READ: retry, latency 4, new data seen.
        issue(5'h0B, 3'd2, 3'd5, 3'd1, 1'b0);
        wb(3'd2, 8'h33);
        wait_valid(n2);
        chk("t031_latency", n2 + 1, 4);
        chk("t031_a", s_out_a, 8'h33);
        chk("t031_b", s_out_b, 8'hA0);

        // Stall in VALID: outputs hold; pending set only on the handshake.
        out_ready = 1'b0;
        issue(5'h11, 3'd2, 3'd5, 3'd6, 1'b1);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t033_hold_valid", s_out_valid, 1'b1);
            chk("t033_hold_a", s_out_a, 8'h33);
            chk("t033_hold_b", s_out_b, 8'hA0);
        end
        out_ready = 1'b1;
        in_ri_a = 3'd0; in_ri_b = 3'd0;
        cycle();
        in_ri_a = 3'd6;
        cycle();
        chk("t033_pend_set", s_in_ready, !SB);
        wb(3'd6, 8'h66);
        cycle();
        chk("t033_pend_clr", s_in_ready, 1'b1);

        // Source hazard until the destination is written back.
        issue(5'h03, 3'd0, 3'd1, 3'd3, 1'b1);
        wait_valid(n);
`ifdef DIBU_SCOREBOARD_EN
        in_valid = 1'b1; in_op = 5'h04; in_ri_a = 3'd3; in_ri_b = 3'd1; in_ri_d = 3'd0; in_wen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t032_stall", s_in_ready, 1'b0);
        end
        wb_valid = 1'b1; wb_ri_d = 3'd3; wb_d = 8'h7E;
        cycle();
        chk("t032_stall_wb", s_in_ready, 1'b0);
        wb_valid = 1'b0;
        cycle();
        chk("t032_accept", s_in_ready, 1'b1);
        in_valid = 1'b0;
`else
        wb(3'd3, 8'h7E);
        issue(5'h04, 3'd3, 3'd1, 3'd0, 1'b0);
`endif
        wait_valid(n);
        chk("t032_a", s_out_a, 8'h7E);

        // Set and clear of the same index in one cycle: set wins.
        issue(5'h05, 3'd0, 3'd1, 3'd4, 1'b1);
        cycle();
        cycle();
        wb_valid = 1'b1; wb_ri_d = 3'd4; wb_d = 8'h44;
        cycle();
        chk("t034_valid", s_out_valid, 1'b1);
        wb_valid = 1'b0;
        in_ri_a = 3'd4; in_ri_b = 3'd0;
        cycle();
        chk("t034_pend", s_in_ready, !SB);

        // Reset in LATCH with a writeback: discarded, no bank write.
        issue(5'h06, 3'd0, 3'd5, 3'd1, 1'b0);
        cycle();
        rst = 1'b1; wb_valid = 1'b1; wb_ri_d = 3'd2; wb_d = 8'hEE;
        cycle();
        chk("t035_rb_rw", s_rb_rw, 1'b0);
        rst = 1'b0; wb_valid = 1'b0; in_ri_a = 3'd4;
        cycle();
        chk("t035_out_valid", s_out_valid, 1'b0);
        chk("t035_pend_clr", s_in_ready, 1'b1);
        chk("t035_out_a", s_out_a, 8'h00);
        chk("t035_bank", bank[2], 8'h33);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_op     = 5'($urandom);
            in_ri_a   = 3'($urandom);
            in_ri_b   = 3'($urandom);
            in_ri_d   = 3'($urandom);
            in_wen    = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 6);
            wb_valid  = ($urandom_range(0, 3) == 0);
            wb_ri_d   = 3'($urandom);
            wb_d      = 8'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
